// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encodings and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] FETCH_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// rtl/fetch_unit_next_pc_calc.sv - combinational next-PC resolution (module next_pc_calc)
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_val,
  input  logic        i_adv_by_imm,
  input  logic        i_adv_gpr,
  input  logic        i_bcond,
  input  logic        i_cond_taken,
  output logic [31:0] o_npc,
  output logic        o_misaligned
);

  logic [31:0] w_seq;
  logic [31:0] w_rel;
  logic [31:0] w_ind;

  // Candidate targets and priority select: JALR, JAL, taken branch, then sequential
  always_comb begin
    w_seq = i_pc + 32'd4;
    w_rel = i_pc + i_imm;
    w_ind = (i_rs1_val + i_imm) & ~32'h1;
    if (i_adv_by_imm && i_adv_gpr) begin
      o_npc = w_ind;
    end else if (i_adv_by_imm) begin
      o_npc = w_rel;
    end else if (i_bcond && i_cond_taken) begin
      o_npc = w_rel;
    end else begin
      o_npc = w_seq;
    end
    o_misaligned = (o_npc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-issue instruction fetch stage; FETCH_MISALIGN_TRAP_EN enables misaligned-target trap
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_inst,
  output logic        o_inst_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  input  logic        i_retire,
  input  logic        i_adv_by_imm,
  input  logic        i_adv_gpr,
  input  logic        i_bcond,
  input  logic        i_cond_taken,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_val,
  input  logic        i_ebreak,
  output logic        o_halted,
  output logic        o_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  w_npc;
  logic [31:0]  w_pc_target;
  logic         w_misaligned;
  logic         w_pc_load;
  logic         w_inst_load;
  logic         w_fault_set;

  next_pc_calc u_next_pc_calc (
    .i_pc         (r_pc),
    .i_imm        (i_imm),
    .i_rs1_val    (i_rs1_val),
    .i_adv_by_imm (i_adv_by_imm),
    .i_adv_gpr    (i_adv_gpr),
    .i_bcond      (i_bcond),
    .i_cond_taken (i_cond_taken),
    .o_npc        (w_npc),
    .o_misaligned (w_misaligned)
  );

  // Without the trap, a misaligned target is silently rounded down to a word boundary
  assign w_pc_target = w_misaligned ? (w_npc & ~32'h3) : w_npc;

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_pc_next   = r_pc + 32'd4;
  assign o_inst      = r_inst;

  // Next-state, handshake outputs and register-update strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_load    = 1'b0;
    w_inst_load  = 1'b0;
    w_fault_set  = 1'b0;
    o_imem_req   = 1'b0;
    o_inst_valid = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_inst_load = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_inst_valid = 1'b1;
        if (i_retire) begin
          if (i_ebreak) begin
            w_state_nxt = S_HALT;
          end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              w_fault_set = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_pc_load   = 1'b1;
              w_state_nxt = S_FETCH;
            end
`else
            w_pc_load   = 1'b1;
            w_state_nxt = S_FETCH;
`endif
          end
        end
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= FETCH_NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_load) begin
        r_pc <= w_pc_target;
      end
      if (w_inst_load) begin
        r_inst <= i_imem_data;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
  logic w_fault_unused;
  assign w_fault_unused = w_fault_set;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_data = '0;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_next;
  logic        i_retire = 1'b0;
  logic        i_adv_by_imm = 1'b0;
  logic        i_adv_gpr = 1'b0;
  logic        i_bcond = 1'b0;
  logic        i_cond_taken = 1'b0;
  logic [31:0] i_imm = '0;
  logic [31:0] i_rs1_val = '0;
  logic        i_ebreak = 1'b0;
  logic        o_halted;
  logic        o_fault;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_data  (i_imem_data),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .o_pc         (o_pc),
    .o_pc_next    (o_pc_next),
    .i_retire     (i_retire),
    .i_adv_by_imm (i_adv_by_imm),
    .i_adv_gpr    (i_adv_gpr),
    .i_bcond      (i_bcond),
    .i_cond_taken (i_cond_taken),
    .i_imm        (i_imm),
    .i_rs1_val    (i_rs1_val),
    .i_ebreak     (i_ebreak),
    .o_halted     (o_halted),
    .o_fault      (o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic fetch_word(input logic [31:0] data, input int delay);
    for (int k = 0; k < delay; k++) tick();
    chk("req_before_ack", {31'd0, o_imem_req}, 32'd1);
    i_imem_ack  = 1'b1;
    i_imem_data = data;
    tick();
    i_imem_ack  = 1'b0;
    i_imem_data = '0;
    chk("valid_after_ack", {31'd0, o_inst_valid}, 32'd1);
  endtask

  task automatic retire(input logic ebreak, input logic adv_gpr, input logic adv_imm,
                        input logic bcond, input logic taken,
                        input logic [31:0] imm, input logic [31:0] rs1);
    i_ebreak = ebreak; i_adv_gpr = adv_gpr; i_adv_by_imm = adv_imm;
    i_bcond = bcond; i_cond_taken = taken; i_imm = imm; i_rs1_val = rs1;
    i_retire = 1'b1;
    tick();
    i_retire = 1'b0; i_ebreak = 1'b0; i_adv_gpr = 1'b0; i_adv_by_imm = 1'b0;
    i_bcond = 1'b0; i_cond_taken = 1'b0; i_imm = '0; i_rs1_val = '0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    chk("rst_inst", o_inst, 32'h0000_0013);
    chk("rst_req", {31'd0, o_imem_req}, 32'd1);
    chk("rst_addr", o_imem_addr, 32'h100);

    // retire outside S_ISSUE is ignored
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("retire_in_fetch_pc", o_pc, 32'h100);

    // first fetch, ack after 3 wait cycles
    tick(); tick();
    chk("wait_addr", o_imem_addr, 32'h100);
    fetch_word(32'h0050_0093, 0);
    chk("t1_inst", o_inst, 32'h0050_0093);
    chk("t1_pc", o_pc, 32'h100);
    chk("t1_pc_next", o_pc_next, 32'h104);
    chk("t1_req_low", {31'd0, o_imem_req}, 32'd0);

    // ack while issuing is ignored
    i_imem_ack = 1'b1; i_imem_data = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 1'b0; i_imem_data = '0;
    chk("ack_in_issue_inst", o_inst, 32'h0050_0093);
    chk("ack_in_issue_valid", {31'd0, o_inst_valid}, 32'd1);

    // sequential, then wrap from 0xFFFFFFFC
    retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("seq_addr", o_imem_addr, 32'h104);
    chk("seq_req", {31'd0, o_imem_req}, 32'd1);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FEF8, 32'h0);
    chk("jal_to_top", o_imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h13, 1);
    chk("wrap_pc_next", o_pc_next, 32'h0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", o_imem_addr, 32'h0);

    // branches around 0x200
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    chk("jal_200", o_imem_addr, 32'h200);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0);
    chk("br_taken", o_imem_addr, 32'h1F8);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("br_not_taken", o_imem_addr, 32'h204);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h5000);
    chk("gpr_only_seq", o_imem_addr, 32'h208);

    // JALR and JAL
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h1001);
    chk("jalr", o_imem_addr, 32'h1010);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("jal", o_imem_addr, 32'h60);

    // EBREAK beats JAL; halt is sticky
    fetch_word(32'h0010_0073, 0);
    retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("ebreak_halted", {31'd0, o_halted}, 32'd1);
    chk("ebreak_pc", o_pc, 32'h60);
    chk("ebreak_req", {31'd0, o_imem_req}, 32'd0);
    chk("ebreak_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("ebreak_fault", {31'd0, o_fault}, 32'd0);
    i_imem_ack = 1'b1; i_imem_data = 32'h1234_5678;
    tick();
    i_imem_ack = 1'b0;
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    chk("halt_sticky", {31'd0, o_halted}, 32'd1);
    chk("halt_pc_hold", o_pc, 32'h60);
    chk("halt_inst_hold", o_inst, 32'h0010_0073);
    do_reset();
    chk("unhalt", {31'd0, o_halted}, 32'd0);
    chk("unhalt_addr", o_imem_addr, 32'h100);

    // misaligned JAL target
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, o_fault}, 32'd1);
    chk("mis_halted", {31'd0, o_halted}, 32'd1);
    chk("mis_pc", o_pc, 32'h40);
`else
    chk("mis_fault", {31'd0, o_fault}, 32'd0);
    chk("mis_halted", {31'd0, o_halted}, 32'd0);
    chk("mis_addr", o_imem_addr, 32'h40);
`endif
    do_reset();
    chk("rst_fault_clear", {31'd0, o_fault}, 32'd0);

    // reset in the middle of a request
    fetch_word(32'h13, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_abort_addr", o_imem_addr, 32'h104);
    tick();
    do_reset();
    chk("abort_req", {31'd0, o_imem_req}, 32'd1);
    chk("abort_addr", o_imem_addr, 32'h100);
    fetch_word(32'h0000_0093, 0);
    chk("abort_refetch_pc", o_pc, 32'h100);
    chk("abort_refetch_inst", o_inst, 32'h0000_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
